// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder built from one full-adder cell and a carry flop.
// Operands are captured on an accepted start and then processed one bit pair
// per clock, LSB first.
// Result: {c_out, sum} = a + b + c_in.
// One operation occupies WIDTH+2 cycles: one capture edge, WIDTH RUN edges
// and one DONE cycle.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset
//   start  - operation request, sampled only while idle
//   a, b   - WIDTH-bit operands, captured on the accept edge
//   c_in   - carry-in, captured on the accept edge
//   sum    - WIDTH-bit result, valid from done and held until the next accept
//   c_out  - final carry-out, same validity window as sum
//   busy   - high while bits are being processed (RUN)
//   done   - one-cycle completion pulse (DONE)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);

    // One extra counter bit keeps the counter at least one bit wide when WIDTH=1.
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_shift_s;
    logic [CNT_W-1:0] count_r;
    logic             carry_r;
    logic             c_out_r;
    logic             busy_r;
    logic             done_r;
    logic             busy_nx_s;
    logic             done_nx_s;
    logic             accept_s;
    logic             last_s;
    logic             fa_s_s;
    logic             fa_co_s;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Full-adder carry bit: majority of the three inputs.
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    // Accept and last-bit qualifiers.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if (state_r == IDLE) begin
            accept_s = start;
        end else if (state_r == RUN) begin
            last_s = (count_r == LAST_CNT);
        end else begin
            accept_s = 1'b0;
            last_s   = 1'b0;
        end
    end

    // The single full-adder cell, fed by the operand LSBs and the carry flop.
    always_comb begin
        fa_s_s  = fa_sum(sh_a_r[0], sh_b_r[0], carry_r);
        fa_co_s = fa_carry(sh_a_r[0], sh_b_r[0], carry_r);
    end

    // Sum register shifted right with the new sum bit entering at the MSB.
    // Written as shift-then-overwrite so that WIDTH=1 needs no empty slice.
    always_comb begin
        sum_shift_s          = sum_r >> 1'b1;
        sum_shift_s[WIDTH-1] = fa_s_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; RUN exits after the edge that processes the last bit.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so busy/done come straight from flops.
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            IDLE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
            RUN: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b0;
            end
            DONE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs; they always equal the decode of state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
        end
    end

    // Datapath: operand capture, bit-serial shifting, carry and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a_r  <= '0;
            sh_b_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            c_out_r <= 1'b0;
            count_r <= '0;
        end else begin
            if (accept_s) begin
                // c_out keeps the previous result until the new one completes.
                sh_a_r  <= a;
                sh_b_r  <= b;
                carry_r <= c_in;
                sum_r   <= '0;
                count_r <= '0;
            end else if (state_r == RUN) begin
                sh_a_r  <= sh_a_r >> 1'b1;
                sh_b_r  <= sh_b_r >> 1'b1;
                sum_r   <= sum_shift_s;
                carry_r <= fa_co_s;
                count_r <= count_r + 1'b1;
                if (last_s) begin
                    c_out_r <= fa_co_s;
                end else begin
                    c_out_r <= c_out_r;
                end
            end else begin
                sh_a_r  <= sh_a_r;
                sh_b_r  <= sh_b_r;
                sum_r   <= sum_r;
                carry_r <= carry_r;
                c_out_r <= c_out_r;
                count_r <= count_r;
            end
        end
    end

    assign sum   = sum_r;
    assign c_out = c_out_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
